// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared constants and helpers for the priority event encoder
//
// Purpose : priority mode selectors and a one-hot decode helper, imported by
//           priority_select and priority_event_encoder.
// Ports   : none (package)

package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Widest request vector the one-hot helper can decode.
  localparam int MAX_N = 64;

  // One-hot decode of idx into an n-wide field.
  // An idx at or above n decodes to all zeros.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/priority_select.sv
// rtl/priority_select.sv - combinational N-to-W priority selector
//
// Purpose : picks one set bit of vec. With rr_en=0 the highest index wins.
//           With rr_en=1 the lowest set index >= start_ptr wins. If no such
//           index exists, the search wraps to the lowest set index overall.
// Ports   : vec       in  N  candidate bits
//           start_ptr in  W  round-robin search start
//           rr_en     in  1  1 = round-robin, 0 = fixed (MSB highest)
//           idx       out W  selected index, 0 when vec is empty
//           any       out 1  vec has at least one bit set

module priority_select #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start_ptr,
  input  logic         rr_en,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic [W-1:0] top_idx;
  logic         hi_found;

  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    top_idx  = '0;
    hi_found = 1'b0;
    // The descending scan leaves the lowest matches in lo_idx and hi_idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lo_idx = W'(i);
        if (i >= int'(start_ptr)) begin
          hi_idx   = W'(i);
          hi_found = 1'b1;
        end
      end
    end
    // The ascending scan leaves the highest set index in top_idx.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        top_idx = W'(i);
      end
    end
  end

  assign any = |vec;
  assign idx = rr_en ? (hi_found ? hi_idx : lo_idx) : top_idx;

endmodule

// File: rtl/priority_event_encoder.sv
// rtl/priority_event_encoder.sv - pending-event capture with a registered valid/ready issue stage
//
// Purpose : collects request events into a pending register. It issues one
//           eligible index at a time through a valid/ready output register,
//           using fixed or round-robin priority. It flags duplicate events.
// Ports   : clk       in  1  rising-edge clock
//           rst       in  1  synchronous active-high reset
//           req_in    in  N  request events
//           mask      in  N  1 = bit not eligible for issue (pending is still held)
//           out_ready in  1  consumer accepts out_idx
//           out_valid out 1  out_idx is valid
//           out_idx   out W  issued index
//           pending   out N  pending register
//           ovf       out 1  one-cycle duplicate-event pulse

module priority_event_encoder
  import prio_enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int RR_MODE = MODE_FIXED,
  localparam int W      = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic [N-1:0] mask,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         ovf
);

  if (N < 2) begin : g_bad_n
    $error("priority_event_encoder: N must be >= 2");
  end
  if (N > MAX_N) begin : g_big_n
    $error("priority_event_encoder: N exceeds MAX_N");
  end

  logic [N-1:0] pending_q, pending_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic         ovf_q, ovf_d;

  logic         fire;
  logic         load;
  logic [N-1:0] clr;
  logic [N-1:0] elig;
  logic [W-1:0] sel_idx;
  logic         sel_any;

  assign fire = out_valid_q & out_ready;
  assign clr  = fire ? N'(onehot(32'(out_idx_q), N)) : '0;
  // The bit being consumed this cycle is excluded, so it is never presented twice.
  assign elig = pending_q & ~mask & ~clr;
  assign load = !out_valid_q || out_ready;

  // The search starts from the post-issue pointer. This lets the index that
  // follows a just-accepted grant be considered first in the same cycle.
  priority_select #(.N(N), .W(W)) u_sel (
    .vec       (elig),
    .start_ptr (rr_ptr_d),
    .rr_en     (RR_MODE == MODE_RR),
    .idx       (sel_idx),
    .any       (sel_any)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (out_idx_q == W'(N - 1)) ? '0 : out_idx_q + W'(1);
    end
  end

  always_comb begin
    // When a bit is cleared and requested in the same cycle, the set wins.
    pending_d   = (pending_q & ~clr) | req_in;
    ovf_d       = |(req_in & pending_q & ~clr);
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    // A presented index is frozen until it is accepted.
    if (load) begin
      out_valid_d = sel_any;
      if (sel_any) begin
        out_idx_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      rr_ptr_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_priority_event_encoder.sv
// tb/tb_priority_event_encoder.sv - directed self-checking bench for priority_event_encoder

module tb_priority_event_encoder;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] f_req, f_mask, f_pend;
  logic       f_ready, f_valid, f_ovf;
  logic [2:0] f_idx;

  logic [4:0] r_req, r_mask, r_pend;
  logic       r_ready, r_valid, r_ovf;
  logic [2:0] r_idx;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  priority_event_encoder #(.N(8), .RR_MODE(0)) u_fix (
    .clk       (clk),
    .rst       (rst),
    .req_in    (f_req),
    .mask      (f_mask),
    .out_ready (f_ready),
    .out_valid (f_valid),
    .out_idx   (f_idx),
    .pending   (f_pend),
    .ovf       (f_ovf)
  );

  priority_event_encoder #(.N(5), .RR_MODE(1)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_in    (r_req),
    .mask      (r_mask),
    .out_ready (r_ready),
    .out_valid (r_valid),
    .out_idx   (r_idx),
    .pending   (r_pend),
    .ovf       (r_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_rr(input string tag, input logic [31:0] exp_idx);
    check({tag, "_valid"}, 32'(r_valid), 32'd1);
    check({tag, "_idx"}, 32'(r_idx), exp_idx);
    check({tag, "_inrange"}, 32'(r_idx < 3'd5), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    f_req = 8'h00; f_mask = 8'h00; f_ready = 1'b0;
    r_req = 5'h00; r_mask = 5'h00; r_ready = 1'b0;
    #1;

    // 1 reset with all requests asserted
    f_req = 8'hFF; r_req = 5'h1F;
    tick(); tick();
    check("rst_pend", 32'(f_pend), 32'h00);
    check("rst_valid", 32'(f_valid), 32'd0);
    check("rst_ovf", 32'(f_ovf), 32'd0);
    check("rst_idx", 32'(f_idx), 32'd0);
    check("rst_rr_pend", 32'(r_pend), 32'h00);
    rst = 1'b0; f_req = 8'h00; r_req = 5'h00;
    tick(); tick();
    check("post_rst_valid", 32'(f_valid), 32'd0);

    // 2 fixed priority, two simultaneous events
    f_ready = 1'b1;
    f_req = 8'b0010_0100;
    tick();
    f_req = 8'h00;
    check("fx_pend", 32'(f_pend), 32'h24);
    tick();
    check("fx_v1", 32'(f_valid), 32'd1);
    check("fx_i1", 32'(f_idx), 32'd5);
    tick();
    check("fx_v2", 32'(f_valid), 32'd1);
    check("fx_i2", 32'(f_idx), 32'd2);
    tick();
    check("fx_v3", 32'(f_valid), 32'd0);
    check("fx_pend_end", 32'(f_pend), 32'h00);
    check("fx_idx_hold", 32'(f_idx), 32'd2);

    // 3 backpressure: a later higher-priority event must not displace idx 2
    f_ready = 1'b0;
    f_req = 8'h04;
    tick();
    f_req = 8'h00;
    tick();
    check("bp_i_t2", 32'(f_idx), 32'd2);
    tick();
    f_req = 8'h80;
    tick();
    f_req = 8'h00;
    check("bp_pend", 32'(f_pend), 32'h84);
    tick();
    check("bp_v_hold", 32'(f_valid), 32'd1);
    check("bp_i_hold", 32'(f_idx), 32'd2);
    f_ready = 1'b1;
    tick();
    check("bp_v7", 32'(f_valid), 32'd1);
    check("bp_i7", 32'(f_idx), 32'd7);
    check("bp_pend7", 32'(f_pend), 32'h80);
    tick();
    check("bp_v_end", 32'(f_valid), 32'd0);
    check("bp_pend_end", 32'(f_pend), 32'h00);

    // 4 mask holds idx 7 pending until the mask is removed
    f_mask = 8'h80;
    f_req = 8'h81;
    tick();
    f_req = 8'h00;
    tick();
    check("mk_v0", 32'(f_valid), 32'd1);
    check("mk_i0", 32'(f_idx), 32'd0);
    tick();
    check("mk_v_masked", 32'(f_valid), 32'd0);
    check("mk_pend", 32'(f_pend), 32'h80);
    f_mask = 8'h00;
    tick();
    check("mk_v7", 32'(f_valid), 32'd1);
    check("mk_i7", 32'(f_idx), 32'd7);
    tick();
    check("mk_v_end", 32'(f_valid), 32'd0);
    check("mk_pend_end", 32'(f_pend), 32'h00);

    // 5 round-robin, N=5, with a wrap-around
    r_ready = 1'b1;
    r_req = 5'b11111;
    tick();
    r_req = 5'b00000;
    tick();
    check_rr("rr0", 32'd0);
    tick();
    check_rr("rr1", 32'd1);
    tick();
    check_rr("rr2", 32'd2);
    tick();
    check_rr("rr3", 32'd3);
    tick();
    check_rr("rr4", 32'd4);
    tick();
    check("rr_v_end", 32'(r_valid), 32'd0);
    r_req = 5'b00011;
    tick();
    r_req = 5'b00000;
    tick();
    check_rr("rr_w0", 32'd0);
    tick();
    check_rr("rr_w1", 32'd1);
    tick();
    check("rr_w_end", 32'(r_valid), 32'd0);

    // 6 overflow on a duplicate event, then reset while an index is presented
    f_ready = 1'b0;
    f_req = 8'h08;
    tick();
    f_req = 8'h00;
    check("ov_t1", 32'(f_ovf), 32'd0);
    tick();
    check("ov_t2", 32'(f_ovf), 32'd0);
    f_req = 8'h08;
    tick();
    f_req = 8'h00;
    check("ov_t3", 32'(f_ovf), 32'd1);
    check("ov_pend", 32'(f_pend), 32'h08);
    tick();
    check("ov_t4", 32'(f_ovf), 32'd0);
    check("ov_i3", 32'(f_idx), 32'd3);
    f_ready = 1'b1;
    tick();
    check("ov_v_after", 32'(f_valid), 32'd0);
    check("ov_pend_after", 32'(f_pend), 32'h00);
    tick();
    check("ov_single", 32'(f_valid), 32'd0);

    f_ready = 1'b0;
    f_req = 8'h41;
    tick();
    f_req = 8'h00;
    tick();
    check("mr_v", 32'(f_valid), 32'd1);
    check("mr_i", 32'(f_idx), 32'd6);
    rst = 1'b1;
    tick();
    check("mr_v0", 32'(f_valid), 32'd0);
    check("mr_i0", 32'(f_idx), 32'd0);
    check("mr_pend0", 32'(f_pend), 32'h00);
    check("mr_ovf0", 32'(f_ovf), 32'd0);
    rst = 1'b0;
    tick();
    check("mr_after", 32'(f_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
